// File: rtl/vedic_div_pkg.sv
// Shared types and helpers for the vedic_div_seq iterative divider.
// Optional feature macro used by the top level: VEDIC_DIV_EARLY_EXIT_EN.
package vedic_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of a counter that must hold 0..n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Fill bit of the quotient reported for a zero divisor.
   localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/vedic_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// conditionally subtract the divisor.
module vedic_div_step #(
   parameter int DVS_W = 4
) (
   input  logic [DVS_W-1:0] p_i,
   input  logic             bit_i,
   input  logic [DVS_W-1:0] divisor_i,
   output logic [DVS_W-1:0] p_o,
   output logic             q_o
);

   logic [DVS_W:0] trial;

   // The incoming partial remainder is always < divisor, so the restored
   // value fits DVS_W bits even though the trial needs one extra bit.
   always_comb begin
      trial = {p_i, bit_i};
      q_o   = (trial >= {1'b0, divisor_i});
      p_o   = q_o ? DVS_W'(trial - {1'b0, divisor_i}) : trial[DVS_W-1:0];
   end

endmodule

// File: rtl/vedic_div_seq.sv
// Iterative unsigned divider, one quotient bit per clock, start/busy request
// and valid/ready result handshake. Optional macro: VEDIC_DIV_EARLY_EXIT_EN.
module vedic_div_seq
   import vedic_div_pkg::*;
#(
   parameter int DVD_W = 8,
   parameter int DVS_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_by_zero
);

   localparam int             CNT_W    = cnt_width(DVD_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

   state_e           state_q, state_d;
   logic [DVS_W-1:0] p_q, p_d;
   logic [DVD_W-1:0] q_q, q_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0] quot_q, quot_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [DVS_W-1:0] step_p;
   logic             step_q;

   vedic_div_step #(.DVS_W(DVS_W)) u_step (
      .p_i       (p_q),
      .bit_i     (q_q[DVD_W-1]),
      .divisor_i (dvs_q),
      .p_o       (step_p),
      .q_o       (step_q)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvs_d = divisor;
               cnt_d = '0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = {DVD_W{DIV0_Q_BIT}};
                  rem_d   = '0;
                  dbz_d   = 1'b1;
               end
`ifdef VEDIC_DIV_EARLY_EXIT_EN
               else if (dividend < DVD_W'(divisor)) begin
                  state_d = DONE;
                  quot_d  = '0;
                  rem_d   = dividend[DVS_W-1:0];
                  dbz_d   = 1'b0;
               end
`endif
               else begin
                  state_d = CALC;
                  p_d     = '0;
                  q_d     = dividend;
               end
            end
         end

         CALC: begin
            p_d   = step_p;
            q_d   = {q_q[DVD_W-2:0], step_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               quot_d  = {q_q[DVD_W-2:0], step_q};
               rem_d   = step_p;
               dbz_d   = 1'b0;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Result registers are separate from the working registers so no partial
   // value ever reaches the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q <= state_d;
         p_q     <= p_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_vedic_div_seq.sv
// Scoreboard bench for vedic_div_seq: a stimulus process pushes reference
// results, a monitor pops and compares whenever out_valid is presented.
module tb_vedic_div_seq;

   localparam int DVD_W = 8;
   localparam int DVS_W = 4;

   typedef struct {
      logic [DVD_W-1:0] q;
      logic [DVS_W-1:0] r;
      logic             z;
      int               vcyc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [DVD_W-1:0] dividend;
   logic [DVS_W-1:0] divisor;
   logic             busy;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [DVD_W-1:0] quotient;
   logic [DVS_W-1:0] remainder;
   logic             div_by_zero;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic rnd_rdy   = 1'b0;
   logic rdy_force = 1'b1;
   exp_t sb[$];

   vedic_div_seq #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom) : rdy_force;
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
   endtask

   // Reference model straight from the arithmetic definition.
   function automatic exp_t model(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                                  input int t);
      exp_t e;
      if (b == '0) begin
         e.q = '1;
         e.r = '0;
         e.z = 1'b1;
         e.vcyc = t;
      end else begin
         e.q = a / DVD_W'(b);
         e.r = DVS_W'(a % DVD_W'(b));
         e.z = 1'b0;
         e.vcyc = t + DVD_W;
`ifdef VEDIC_DIV_EARLY_EXIT_EN
         if (a < DVD_W'(b)) e.vcyc = t;
`endif
      end
      return e;
   endfunction

   // Monitor: latency on the rising out_valid, data every valid cycle
   // (covers the hold-while-stalled rule), pop on handshake.
   always @(negedge clk) begin
      static logic prev_v = 1'b0;
      exp_t e;
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               fail_event("unexpected_result");
            end else begin
               e = sb[0];
               if (!prev_v) check("latency", cyc, e.vcyc);
               check("quotient", quotient, e.q);
               check("remainder", remainder, e.r);
               check("div_by_zero", div_by_zero, e.z);
               check("busy_in_done", busy, 1);
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev_v = out_valid;
      end
   end

   task automatic issue(input int dvd, input int dvs, output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) fail_event("issue_timeout");
      start    = 1'b1;
      dividend = DVD_W'(dvd);
      divisor  = DVS_W'(dvs);
      @(posedge clk);
      #1;
      t = cyc;
      sb.push_back(model(DVD_W'(dvd), DVS_W'(dvs), t));
      start    = 1'b0;
      dividend = DVD_W'($urandom);
      divisor  = DVS_W'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || sb.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy || sb.size() != 0) fail_event(name);
   endtask

   initial begin
      int t0, t1, t2, n;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(241, 14, t0);
      wait_idle("idle_after_241");

      // Back-to-back: each accept only after the previous handshake.
      issue(200, 8, t0);
      issue(204, 8, t1);
      issue(234, 8, t2);
      check("throughput_1", t1 - t0, DVD_W + 2);
      check("throughput_2", t2 - t1, DVD_W + 2);
      wait_idle("idle_after_b2b");

      issue(100, 0, t0);
      wait_idle("idle_after_div0");

      // Stall the result and hammer start during CALC and DONE.
      rdy_force = 1'b0;
      @(negedge clk);
      issue(200, 8, t0);
      start    = 1'b1;
      dividend = 8'd7;
      divisor  = 4'd1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_event("stall_wait_valid");
      repeat (5) @(negedge clk);
      check("stall_still_valid", out_valid, 1);
      rdy_force = 1'b1;
      n = 0;
      while (!(out_valid && out_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle("idle_after_stall");
      repeat (DVD_W + 4) @(negedge clk);
      check("stall_no_extra_busy", busy, 0);

      // Asynchronous reset in the middle of CALC.
      issue(241, 14, t0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_quotient", quotient, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_dbz", div_by_zero, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(200, 8, t0);
      wait_idle("idle_after_midrst");

      issue(9, 14, t0);
      wait_idle("idle_after_small");

      // Randomised phase with random back-pressure.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int a, b;
         a = (i % 5 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 15));
         issue(a, b, t0);
      end
      wait_idle("idle_after_random");
      rnd_rdy = 1'b0;

      repeat (DVD_W + 4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      check("final_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
